fetch_stage_btb: RTL and testbench
==================================

Name: fetch_stage_btb

Overview:
Parametrised instruction-fetch stage: PC register, next-PC selection, direct-mapped branch target buffer (BTB) and IF/ID pipeline register in one block.
- Sits between the hazard/control unit and the decode stage.
- Drives a combinational instruction memory.
- Adds branch prediction and resolved-branch redirect on top of the PC/MUX/IFID arrangement.

Parameters:
ADDR_W, 32, PC/address width in bits
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value after reset (ADDR_W bits, word aligned)
BTB_ENTRIES, 16, BTB depth; power of two, >= 2

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous reset, active-high
PCWrite  in  1  PC update enable (0 = stall PC)
IFIDWrite  in  1  IF/ID register load enable (0 = hold)
IF_Flush  in  1  insert bubble into IF/ID
Jump  in  1  unconditional jump request
Jump_Addr  in  ADDR_W  jump target
Redirect  in  1  branch mispredict/resolve correction from EX
Redirect_Addr  in  ADDR_W  correct next PC
Upd_Valid  in  1  BTB update strobe from EX
Upd_PC  in  ADDR_W  PC of resolved branch
Upd_Target  in  ADDR_W  resolved branch target
Upd_Taken  in  1  resolved branch outcome
Imem_Data  in  INSTR_W  instruction read at Imem_Addr (combinational)
Imem_Addr  out  ADDR_W  fetch address (= PC)
PC  out  ADDR_W  current PC
ID_Instruction  out  INSTR_W  registered instruction
ID_PC_4  out  ADDR_W  registered PC+4
ID_Pred_Taken  out  1  fetch was predicted taken
ID_Valid  out  1  ID slot holds a real instruction

Behaviour:
- Reset (RESET=1 at edge):
  - PC=RESET_PC.
  - ID_Instruction=0, ID_PC_4=0, ID_Pred_Taken=0, ID_Valid=0.
  - All BTB valid bits cleared.
  - Reset mid-operation discards everything.
- PC indexing, with IB = log2(BTB_ENTRIES):
  - index = PC[IB+1:2]
  - tag = PC[ADDR_W-1:IB+2]
  - PC[1:0] is ignored.
- Lookup (combinational on current PC): hit = valid[index] && tag match. Pred_Taken = hit && predictor state taken.
- PC+4 computed modulo 2^ADDR_W (all-ones wraps to 0x...03 region naturally, no saturation).
- Next-PC priority: Redirect > Jump > Pred_Taken (BTB target) > PC+4.
- PC load rules:
  - Redirect loads Redirect_Addr even when PCWrite=0.
  - All other sources load only when PCWrite=1; otherwise PC holds.
- IF/ID register, priority order:
  1. If IF_Flush or Redirect: load bubble (instr 0, PC_4 0, pred 0, valid 0), regardless of IFIDWrite.
  2. Else if IFIDWrite: load Imem_Data, PC+4, Pred_Taken, valid 1.
  3. Else hold all fields.
- Latency: instruction at PC appears on ID_* one edge later.
- BTB update on Upd_Valid at edge, index/tag from Upd_PC:
  - Hit: target <= Upd_Target if Upd_Taken; predictor state updated.
  - Miss and Upd_Taken: allocate (valid=1, tag, target, state=taken initial); overwrites the previous occupant.
  - Miss and not taken: no change.
  - Write visible from next cycle only. A same-cycle lookup of the same index sees old contents (no bypass).
- Update and lookup are independent: no stall is generated by the block.

Optional Feature:
BTB_2BIT_EN
- Defined: 2-bit saturating counter per entry.
  - Allocate at 2'b10 (weakly taken).
  - Taken increments (saturate at 11); not-taken decrements (saturate at 00).
  - Predict taken when MSB=1.
- Undefined: 1-bit state per entry; state <= Upd_Taken on every hit update; allocate at 1.

Test Plan:
1. Sequential fetch:
   - Stimulus: RESET 1 cycle, then PCWrite=IFIDWrite=1, no other controls.
   - Required: PC 0,4,8,12 on successive edges; ID_PC_4 4,8,12; ID_Valid=1 from first post-reset edge.
2. Jump and stall:
   - Jump=1, Jump_Addr=0x40, PCWrite=1 -> PC=0x40 next edge.
   - Same with PCWrite=0 -> PC holds.
   - PCWrite=IFIDWrite=0 for 2 cycles -> PC, ID_Instruction, ID_PC_4 unchanged.
3. BTB prediction:
   - Update: Upd_Valid, Upd_PC=0x10, Upd_Target=0x100, Upd_Taken=1.
   - Then fetch reaches PC=0x10 -> next PC=0x100, ID_Pred_Taken=1, ID_PC_4=0x14.
   - Updating in the same cycle PC=0x10 is looked up -> no prediction that cycle.
4. Predictor hysteresis (0x10 entry):
   - Stimulus: two taken updates, then one not-taken update.
   - BTB_2BIT_EN defined: still predicts 0x100.
   - BTB_2BIT_EN undefined: predicts not taken, next PC=0x14.
5. Flush vs hold:
   - IF_Flush=1 with IFIDWrite=0 -> ID_Instruction=0, ID_Valid=0, ID_Pred_Taken=0 next edge.
   - PC still advances if PCWrite=1.
6. Redirect priority and reset:
   - Redirect=1, Redirect_Addr=0x200, Jump=1, Jump_Addr=0x40, PCWrite=0 -> PC=0x200, ID bubble.
   - Then RESET mid-run -> PC=RESET_PC and previously allocated 0x10 entry no longer predicts.

Source files
------------

// File: rtl/fetch_stage_btb.sv
// Instruction-fetch stage: PC register, next-PC select, direct-mapped BTB and IF/ID register.
// Define BTB_2BIT_EN for 2-bit saturating predictors; otherwise each entry holds a 1-bit state.
module fetch_stage_btb #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       INSTR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int unsigned       BTB_ENTRIES = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               PCWrite,
   input  logic               IFIDWrite,
   input  logic               IF_Flush,
   input  logic               Jump,
   input  logic [ADDR_W-1:0]  Jump_Addr,
   input  logic               Redirect,
   input  logic [ADDR_W-1:0]  Redirect_Addr,
   input  logic               Upd_Valid,
   input  logic [ADDR_W-1:0]  Upd_PC,
   input  logic [ADDR_W-1:0]  Upd_Target,
   input  logic               Upd_Taken,
   input  logic [INSTR_W-1:0] Imem_Data,
   output logic [ADDR_W-1:0]  Imem_Addr,
   output logic [ADDR_W-1:0]  PC,
   output logic [INSTR_W-1:0] ID_Instruction,
   output logic [ADDR_W-1:0]  ID_PC_4,
   output logic               ID_Pred_Taken,
   output logic               ID_Valid
);

   localparam int unsigned IB    = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IB - 2;

`ifdef BTB_2BIT_EN
   localparam int unsigned      ST_W     = 2;
   localparam logic [ST_W-1:0]  ST_ALLOC = 2'b10;
`else
   localparam int unsigned      ST_W     = 1;
   localparam logic [ST_W-1:0]  ST_ALLOC = 1'b1;
`endif

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
   logic [ADDR_W-1:0]      btb_target [BTB_ENTRIES];
   logic [ST_W-1:0]        btb_state  [BTB_ENTRIES];

   logic [IB-1:0]     look_idx;
   logic [TAG_W-1:0]  look_tag;
   logic              look_hit;
   logic              pred_taken;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] next_pc;

   logic [IB-1:0]     upd_idx;
   logic [TAG_W-1:0]  upd_tag;
   logic              upd_hit;
   logic [ST_W-1:0]   upd_state;
   logic              unused_upd_low;

   assign unused_upd_low = ^Upd_PC[1:0];

   // Lookup on the current PC; prediction uses the state MSB in both predictor widths
   assign look_idx   = PC[IB+1:2];
   assign look_tag   = PC[ADDR_W-1:IB+2];
   assign look_hit   = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
   assign pred_taken = look_hit && btb_state[look_idx][ST_W-1];
   assign pc_plus4   = PC + ADDR_W'(4);
   assign Imem_Addr  = PC;

   always_comb begin
      next_pc = pc_plus4;
      if (Redirect)
         next_pc = Redirect_Addr;
      else if (Jump)
         next_pc = Jump_Addr;
      else if (pred_taken)
         next_pc = btb_target[look_idx];
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         PC <= RESET_PC;
      else if (Redirect || PCWrite)
         PC <= next_pc;
   end

   always_ff @(posedge CLK) begin
      if (RESET || IF_Flush || Redirect) begin
         ID_Instruction <= '0;
         ID_PC_4        <= '0;
         ID_Pred_Taken  <= 1'b0;
         ID_Valid       <= 1'b0;
      end else if (IFIDWrite) begin
         ID_Instruction <= Imem_Data;
         ID_PC_4        <= pc_plus4;
         ID_Pred_Taken  <= pred_taken;
         ID_Valid       <= 1'b1;
      end
   end

   assign upd_idx = Upd_PC[IB+1:2];
   assign upd_tag = Upd_PC[ADDR_W-1:IB+2];
   assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

   always_comb begin
      upd_state = btb_state[upd_idx];
`ifdef BTB_2BIT_EN
      if (Upd_Taken) begin
         if (upd_state != '1)
            upd_state = upd_state + 1'b1;
      end else if (upd_state != '0) begin
         upd_state = upd_state - 1'b1;
      end
`else
      upd_state = Upd_Taken;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         btb_valid <= '0;
      else if (Upd_Valid && !upd_hit && Upd_Taken)
         btb_valid[upd_idx] <= 1'b1;
   end

   // Payload needs no reset: an entry is only read once its valid bit is set by allocation
   always_ff @(posedge CLK) begin
      if (Upd_Valid) begin
         if (upd_hit) begin
            if (Upd_Taken)
               btb_target[upd_idx] <= Upd_Target;
            btb_state[upd_idx] <= upd_state;
         end else if (Upd_Taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= Upd_Target;
            btb_state[upd_idx]  <= ST_ALLOC;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage_btb.sv
// Bench for fetch_stage_btb: directed plan steps then random traffic against a behavioural model.
// Honors BTB_2BIT_EN the same way as the design.
module tb_fetch_stage_btb;

   localparam int unsigned NE = 16;
   localparam int unsigned IB = 4;

   logic        CLK = 1'b0;
   logic        RESET, PCWrite, IFIDWrite, IF_Flush, Jump, Redirect;
   logic        Upd_Valid, Upd_Taken;
   logic [31:0] Jump_Addr, Redirect_Addr, Upd_PC, Upd_Target;
   logic [31:0] Imem_Data, Imem_Addr, PC, ID_Instruction, ID_PC_4;
   logic        ID_Pred_Taken, ID_Valid;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   bit [31:0] m_pc, m_instr, m_pc4;
   bit        m_pred, m_valid;
   bit        b_v   [NE];
   bit [31:0] b_tag [NE];
   bit [31:0] b_tgt [NE];
   int        b_ctr [NE];

   fetch_stage_btb #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .BTB_ENTRIES(NE)) dut (
      .CLK(CLK), .RESET(RESET), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IF_Flush(IF_Flush),
      .Jump(Jump), .Jump_Addr(Jump_Addr), .Redirect(Redirect), .Redirect_Addr(Redirect_Addr),
      .Upd_Valid(Upd_Valid), .Upd_PC(Upd_PC), .Upd_Target(Upd_Target), .Upd_Taken(Upd_Taken),
      .Imem_Data(Imem_Data), .Imem_Addr(Imem_Addr), .PC(PC), .ID_Instruction(ID_Instruction),
      .ID_PC_4(ID_PC_4), .ID_Pred_Taken(ID_Pred_Taken), .ID_Valid(ID_Valid)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return a * 32'h9E3779B1 + 32'h01234567;
   endfunction

   assign Imem_Data = imem_word(Imem_Addr);

   function automatic bit ctr_taken(input int c);
`ifdef BTB_2BIT_EN
      return c >= 2;
`else
      return c != 0;
`endif
   endfunction

   function automatic int ctr_next(input int c, input bit tk);
`ifdef BTB_2BIT_EN
      if (tk) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
`else
      return tk ? 1 : 0;
`endif
   endfunction

   function automatic int ctr_alloc();
`ifdef BTB_2BIT_EN
      return 2;
`else
      return 1;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      RESET = 0; PCWrite = 1; IFIDWrite = 1; IF_Flush = 0; Jump = 0; Redirect = 0;
      Upd_Valid = 0; Upd_Taken = 0;
      Jump_Addr = '0; Redirect_Addr = '0; Upd_PC = '0; Upd_Target = '0;
   endtask

   // Predict from current model state, advance one clock, compare every output.
   task automatic step();
      int unsigned li, ui;
      bit          pred, uhit;
      bit [31:0]   pc4, n_pc, n_instr, n_pc4;
      bit          n_pred, n_valid;
      li   = (m_pc >> 2) % NE;
      pred = b_v[li] && (b_tag[li] == (m_pc >> (IB + 2))) && ctr_taken(b_ctr[li]);
      pc4  = m_pc + 32'd4;
      n_pc = m_pc;
      if (Redirect)      n_pc = Redirect_Addr;
      else if (PCWrite)  n_pc = Jump ? Jump_Addr : (pred ? b_tgt[li] : pc4);
      {n_instr, n_pc4, n_pred, n_valid} = {m_instr, m_pc4, m_pred, m_valid};
      if (IF_Flush || Redirect) {n_instr, n_pc4, n_pred, n_valid} = '0;
      else if (IFIDWrite) {n_instr, n_pc4, n_pred, n_valid} = {imem_word(m_pc), pc4, pred, 1'b1};
      @(posedge CLK);
      #1;
      if (Upd_Valid) begin
         ui   = (Upd_PC >> 2) % NE;
         uhit = b_v[ui] && (b_tag[ui] == (Upd_PC >> (IB + 2)));
         if (uhit) begin
            if (Upd_Taken) b_tgt[ui] = Upd_Target;
            b_ctr[ui] = ctr_next(b_ctr[ui], Upd_Taken);
         end else if (Upd_Taken) begin
            b_v[ui] = 1; b_tag[ui] = Upd_PC >> (IB + 2); b_tgt[ui] = Upd_Target;
            b_ctr[ui] = ctr_alloc();
         end
      end
      {m_pc, m_instr, m_pc4, m_pred, m_valid} = {n_pc, n_instr, n_pc4, n_pred, n_valid};
      if (RESET) begin
         {m_pc, m_instr, m_pc4, m_pred, m_valid} = '0;
         foreach (b_v[k]) b_v[k] = 0;
      end
      check("pc", PC, m_pc);
      check("imem_addr", Imem_Addr, m_pc);
      check("id_instr", ID_Instruction, m_instr);
      check("id_pc4", ID_PC_4, m_pc4);
      check("id_pred", ID_Pred_Taken, m_pred);
      check("id_valid", ID_Valid, m_valid);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 6))
         0: return 32'h10;
         1: return 32'h50;
         2: return 32'h100;
         3: return 32'hFFFF_FFFC;
         4: return 32'h14;
         5: return {$urandom_range(0, 63), 2'b00};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      foreach (b_v[k]) begin b_v[k] = 0; b_tag[k] = 0; b_tgt[k] = 0; b_ctr[k] = 0; end
      idle();
      RESET = 1; step();
      check("rst_pc", PC, 32'h0);
      check("rst_valid", ID_Valid, 1'b0);
      idle();

      // sequential fetch
      step(); check("seq_pc4", PC, 32'h4); check("seq_idpc4", ID_PC_4, 32'h4);
      check("seq_valid", ID_Valid, 1'b1);
      step(); check("seq_pc8", PC, 32'h8);
      step(); check("seq_pc12", PC, 32'hC); check("seq_idpc12", ID_PC_4, 32'hC);

      // jump and stall
      Jump = 1; Jump_Addr = 32'h40; step(); check("jump_pc", PC, 32'h40);
      Jump_Addr = 32'h80; PCWrite = 0; step(); check("jump_stall_pc", PC, 32'h40);
      Jump = 0; IFIDWrite = 0;
      step(); step();
      check("stall_pc", PC, 32'h40);
      check("stall_instr", ID_Instruction, imem_word(32'h40));
      check("stall_idpc4", ID_PC_4, 32'h44);

      // BTB: same-cycle update sees old contents, then prediction
      idle(); Jump = 1; Jump_Addr = 32'h10; step(); idle();
      Upd_Valid = 1; Upd_PC = 32'h10; Upd_Target = 32'h100; Upd_Taken = 1; step(); idle();
      check("byp_pc", PC, 32'h14); check("byp_pred", ID_Pred_Taken, 1'b0);
      Jump = 1; Jump_Addr = 32'h10; step(); idle();
      step();
      check("pred_pc", PC, 32'h100); check("pred_flag", ID_Pred_Taken, 1'b1);
      check("pred_idpc4", ID_PC_4, 32'h14);

      // hysteresis
      PCWrite = 0; IFIDWrite = 0; Upd_Valid = 1; Upd_PC = 32'h10; Upd_Target = 32'h100;
      Upd_Taken = 1; step(); step();
      Upd_Taken = 0; step(); idle();
      Jump = 1; Jump_Addr = 32'h10; step(); idle();
      step();
`ifdef BTB_2BIT_EN
      check("hyst_pc", PC, 32'h100);
`else
      check("hyst_pc", PC, 32'h14);
`endif

      // flush vs hold
      IF_Flush = 1; IFIDWrite = 0; step(); idle();
      check("flush_instr", ID_Instruction, 32'h0); check("flush_valid", ID_Valid, 1'b0);
      check("flush_pred", ID_Pred_Taken, 1'b0);
`ifdef BTB_2BIT_EN
      check("flush_pc", PC, 32'h104);
`else
      check("flush_pc", PC, 32'h18);
`endif

      // redirect priority, then reset discards BTB
      Redirect = 1; Redirect_Addr = 32'h200; Jump = 1; Jump_Addr = 32'h40; PCWrite = 0;
      step(); idle();
      check("redir_pc", PC, 32'h200); check("redir_valid", ID_Valid, 1'b0);
      RESET = 1; step(); idle();
      check("rst2_pc", PC, 32'h0);
      Jump = 1; Jump_Addr = 32'h10; step(); idle();
      step();
      check("rst2_nopred_pc", PC, 32'h14); check("rst2_nopred", ID_Pred_Taken, 1'b0);

      // PC+4 wraps
      Jump = 1; Jump_Addr = 32'hFFFF_FFFC; step(); idle();
      step();
      check("wrap_pc", PC, 32'h0); check("wrap_idpc4", ID_PC_4, 32'h0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         RESET         = ($urandom_range(0, 49) == 0);
         PCWrite       = ($urandom_range(0, 9) < 8);
         IFIDWrite     = ($urandom_range(0, 9) < 8);
         IF_Flush      = ($urandom_range(0, 9) == 0);
         Jump          = ($urandom_range(0, 9) == 0);
         Jump_Addr     = pick_addr();
         Redirect      = ($urandom_range(0, 11) == 0);
         Redirect_Addr = pick_addr();
         Upd_Valid     = ($urandom_range(0, 9) < 4);
         Upd_PC        = ($urandom_range(0, 1) == 0) ? PC : pick_addr();
         Upd_Target    = pick_addr();
         Upd_Taken     = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
